// File: rtl/sa_ws_scheduler.sv
// sa_ws_scheduler: weight-stationary sequencing controller for one SA_MxN
// systolic array carrying 64-bit IEEE-754 doubles. Data passes bit-exact.
//
// Each command preloads the MxN weight matrix, then streams K A-row vectors
// into the array with a per-lane skew. The array's out_bottom lanes are
// deskewed into whole result rows and returned through a small FIFO.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake (accepted only in IDLE)
//   cmd_rows, cmd_weights   K and W (element i*N+j = W[i][j]), captured on accept
//   a_valid/a_ready/a_data  A-row stream, lane i = A[r][i]
//   r_valid/r_ready/r_data  result-row stream, lane j = C[r][j]; r_last on row K-1
//   busy, done              controller active / one-cycle completion pulse
//   sa_*                    all control and data inputs of the array, plus out_bottom
module sa_ws_scheduler #(
  parameter int M         = 3,
  parameter int N         = 3,
  parameter int SA_LAT    = 4,
  parameter int RES_DEPTH = 4,
  parameter int KW        = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [KW-1:0]      cmd_rows,
  input  logic [64*M*N-1:0]  cmd_weights,
  input  logic               a_valid,
  output logic               a_ready,
  input  logic [64*M-1:0]    a_data,
  output logic               r_valid,
  input  logic               r_ready,
  output logic [64*N-1:0]    r_data,
  output logic               r_last,
  output logic               busy,
  output logic               done,
  output logic               sa_output_stationary,
  output logic               sa_preload_valid,
  output logic [64*M*N-1:0]  sa_preload_data,
  output logic [64*M-1:0]    sa_in_left,
  output logic [64*N-1:0]    sa_in_top,
  input  logic [64*N-1:0]    sa_out_bottom
);

  // A beat at cycle t reaches the FIFO write port at cycle t+SA_LAT+N.
  localparam int PIPE = SA_LAT + N;
  localparam int PW   = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int CW   = $clog2(RES_DEPTH + 1);

  typedef enum logic [2:0] {IDLE, PRELOAD, STREAM, DRAIN, DONE} state_t;

  state_t          state;
  logic [KW-1:0]   k_rows;
  logic [KW-1:0]   issued;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     credit_used;
  logic [PIPE-1:0] v_pipe;
  logic [PIPE-1:0] l_pipe;
  logic [64*N-1:0] row_aligned;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            beat;
  logic            push;
  logic            pop;
  logic [64*N:0]   mem [RES_DEPTH];
  logic [64*N:0]   rd_word;

  assign sa_output_stationary = 1'b0;
  assign sa_in_top            = '0;
  assign busy                 = (state != IDLE);

  // Credits cover both rows still inside the array and rows parked in the
  // FIFO, so a push can never find the FIFO full.
  assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
  assign a_ready     = (state == STREAM) && (issued < k_rows) &&
                       (credit_used < (CW+1)'(RES_DEPTH));
  assign beat        = a_valid && a_ready;
  assign push        = v_pipe[PIPE-1];
  assign r_valid     = (fifo_count != '0);
  assign pop         = r_valid && r_ready;

  // Controller FSM with registered handshake/strobe outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      cmd_ready        <= 1'b0;
      done             <= 1'b0;
      sa_preload_valid <= 1'b0;
      sa_preload_data  <= '0;
      k_rows           <= '0;
      issued           <= '0;
    end else begin
      done             <= 1'b0;
      sa_preload_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready        <= 1'b0;
            k_rows           <= cmd_rows;
            sa_preload_data  <= cmd_weights;
            issued           <= '0;
            sa_preload_valid <= 1'b1;
            state            <= PRELOAD;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        PRELOAD: state <= (k_rows == '0) ? DRAIN : STREAM;
        STREAM: begin
          if (beat) begin
            issued <= issued + KW'(1);
            if (issued == k_rows - KW'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          // Finish in the same cycle the final row is popped.
          if (inflight == '0 &&
              (fifo_count == '0 || (fifo_count == CW'(1) && pop))) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Input skew: lane i sees the beat i+1 cycles later; idle cycles inject zeros.
  for (genvar i = 0; i < M; i++) begin : g_skew
    logic [63:0] sk [i+1];
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int d = 0; d <= i; d++) sk[d] <= '0;
      end else begin
        sk[0] <= beat ? a_data[i*64 +: 64] : 64'd0;
        for (int d = 1; d <= i; d++) sk[d] <= sk[d-1];
      end
    end
    assign sa_in_left[i*64 +: 64] = sk[i];
  end

  // Output deskew: lane j leaves the array j cycles after lane 0, so it is
  // delayed N-1-j cycles to line the whole row up with lane N-1.
  for (genvar j = 0; j < N; j++) begin : g_deskew
    localparam int D = N - 1 - j;
    if (D == 0) begin : g_direct
      assign row_aligned[j*64 +: 64] = sa_out_bottom[j*64 +: 64];
    end else begin : g_delay
      logic [63:0] dl [D];
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int d = 0; d < D; d++) dl[d] <= '0;
        end else begin
          dl[0] <= sa_out_bottom[j*64 +: 64];
          for (int d = 1; d < D; d++) dl[d] <= dl[d-1];
        end
      end
      assign row_aligned[j*64 +: 64] = dl[D-1];
    end
  end

  // Row tracking pipe and credit/occupancy counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_pipe     <= '0;
      l_pipe     <= '0;
      inflight   <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      v_pipe <= {v_pipe[PIPE-2:0], beat};
      l_pipe <= {l_pipe[PIPE-2:0], beat && (issued == k_rows - KW'(1))};
      case ({beat, push})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (push) wr_ptr <= (wr_ptr == PW'(RES_DEPTH-1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(RES_DEPTH-1)) ? '0 : rd_ptr + PW'(1);
    end
  end

  // NOTE: the FIFO storage is deliberately not reset; the empty flag (count)
  // is reset, and the read port is gated by r_valid so stale words never leak.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {l_pipe[PIPE-1], row_aligned};
  end

  assign rd_word = mem[rd_ptr];
  assign r_data  = r_valid ? rd_word[64*N-1:0] : '0;
  assign r_last  = r_valid && rd_word[64*N];

endmodule

// File: tb/tb_sa_ws_scheduler.sv
// Testbench for sa_ws_scheduler. A behavioural SA model drives out_bottom
// from the recorded in_left history; expected rows are computed as A x W.
module tb_sa_ws_scheduler;
  localparam int M = 3, N = 3, SA_LAT = 4, RES_DEPTH = 4, KW = 8, H = 64;

  logic               clk, reset_n;
  logic               cmd_valid, cmd_ready;
  logic [KW-1:0]      cmd_rows;
  logic [64*M*N-1:0]  cmd_weights;
  logic               a_valid, a_ready;
  logic [64*M-1:0]    a_data;
  logic               r_valid, r_ready, r_last;
  logic [64*N-1:0]    r_data;
  logic               busy, done;
  logic               sa_output_stationary, sa_preload_valid;
  logic [64*M*N-1:0]  sa_preload_data;
  logic [64*M-1:0]    sa_in_left;
  logic [64*N-1:0]    sa_in_top;
  logic [64*N-1:0]    sa_out_bottom;

  sa_ws_scheduler #(.M(M), .N(N), .SA_LAT(SA_LAT), .RES_DEPTH(RES_DEPTH), .KW(KW)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rows(cmd_rows), .cmd_weights(cmd_weights),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_last(r_last),
    .busy(busy), .done(done),
    .sa_output_stationary(sa_output_stationary), .sa_preload_valid(sa_preload_valid),
    .sa_preload_data(sa_preload_data), .sa_in_left(sa_in_left), .sa_in_top(sa_in_top),
    .sa_out_bottom(sa_out_bottom)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stimulus / reference state
  real               cur_w [M][N];
  real               w_sa  [M][N];
  logic [64*M-1:0]   a_buf [16];
  logic [63:0]       hist  [H][M];
  logic [64*N:0]     exp_q [$];
  int cyc = 0, cur_k = 0;
  int beats = 0, pops = 0, first_beat = -1, first_rv = -1, last_pop = -1;
  int done_cyc = -1, accept_cyc = -1, preload_cnt = 0;
  bit stall_prev = 0, finished = 0;
  logic [64*N-1:0] data_prev;
  logic            last_prev;

  function automatic logic [64*N-1:0] mul_row(input logic [64*M-1:0] a);
    logic [64*N-1:0] r;
    real acc;
    r = '0;
    for (int j = 0; j < N; j++) begin
      acc = 0.0;
      for (int i = 0; i < M; i++) acc = acc + $bitstoreal(a[i*64 +: 64]) * cur_w[i][j];
      r[j*64 +: 64] = $realtobits(acc);
    end
    return r;
  endfunction

  function automatic logic [64*M-1:0] row3(input real a0, input real a1, input real a2);
    return {$realtobits(a2), $realtobits(a1), $realtobits(a0)};
  endfunction

  // Negedge: SA model, expected-row bookkeeping and result checking.
  always @(negedge clk) begin
    logic [64*N-1:0] ob;
    logic [64*N:0]   e;
    real acc;
    int idx;
    for (int i = 0; i < M; i++) hist[cyc % H][i] = sa_in_left[i*64 +: 64];
    if (sa_preload_valid)
      for (int i = 0; i < M; i++)
        for (int j = 0; j < N; j++)
          w_sa[i][j] = $bitstoreal(sa_preload_data[(i*N+j)*64 +: 64]);
    for (int j = 0; j < N; j++) begin
      acc = 0.0;
      for (int i = 0; i < M; i++) begin
        idx = cyc - SA_LAT - j + i;
        if (idx >= 0) acc = acc + $bitstoreal(hist[idx % H][i]) * w_sa[i][j];
      end
      ob[j*64 +: 64] = $realtobits(acc);
    end
    sa_out_bottom = ob;

    if (!reset_n) begin
      exp_q.delete();
      stall_prev = 0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        accept_cyc = cyc; preload_cnt = 0; beats = 0; pops = 0;
        first_beat = -1; first_rv = -1; last_pop = -1; done_cyc = -1;
      end
      if (sa_preload_valid) preload_cnt++;
      if (a_ready) check("credit", 256'((beats - pops) < RES_DEPTH), 256'(1));
      if (a_valid && a_ready) begin
        if (first_beat < 0) first_beat = cyc;
        exp_q.push_back({beats == cur_k - 1, mul_row(a_data)});
        beats++;
      end
      if (r_valid && first_rv < 0) first_rv = cyc;
      if (stall_prev) check("hold", {r_valid, r_last, r_data}, {1'b1, last_prev, data_prev});
      if (r_valid && r_ready) begin
        if (exp_q.size() == 0) check("extra_row", 256'(1), 256'(0));
        else begin
          e = exp_q.pop_front();
          check("row_data", r_data, e[64*N-1:0]);
          check("row_last", r_last, e[64*N]);
        end
        pops++;
        last_pop = cyc;
      end
      stall_prev = r_valid && !r_ready;
      data_prev  = r_data;
      last_prev  = r_last;
      if (done) done_cyc = cyc;
    end
    cyc++;
  end

  task automatic issue_cmd(input int k);
    int t;
    cur_k = k;
    cmd_rows = KW'(k);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++)
        cmd_weights[(i*N+j)*64 +: 64] = $realtobits(cur_w[i][j]);
    cmd_valid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!cmd_ready && t < 100);
    check("cmd_ready_wait", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drive_a(input int k, input int mode);
    int idx = 0, t = 0;
    bit phase = 1, v, got;
    while (idx < k && t < 3000) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? phase : 1'($urandom_range(0, 1));
      phase = ~phase;
      a_valid = v;
      a_data  = v ? a_buf[idx] : {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      got = a_valid && a_ready;
      @(posedge clk); #1;
      t++;
      if (got) idx++;
    end
    a_valid = 1'b0;
  endtask

  task automatic drive_r(input int mode);
    int t = 0;
    while (!finished && t < 4000) begin
      if (mode == 2 && t == 30) begin
        check("bp_beats", beats, RES_DEPTH);
        check("bp_a_ready", a_ready, 0);
        check("bp_r_valid", r_valid, 1);
      end
      case (mode)
        0:       r_ready = 1'b1;
        1:       r_ready = 1'($urandom_range(0, 1));
        default: r_ready = (t >= 30);
      endcase
      @(posedge clk); #1;
      t++;
    end
    r_ready = 1'b0;
  endtask

  task automatic wait_done(input int k);
    int t = 0;
    do begin @(negedge clk); t++; end while (!done && t < 3000);
    check("done_seen", done, 1);
    finished = 1;
    #1;
    if (k > 0) begin
      check("done_after_pop", done_cyc - last_pop, 1);
      check("first_latency", first_rv - first_beat, SA_LAT + N + 1);
    end else begin
      check("done_k0", done_cyc - accept_cyc, 3);
      check("no_rvalid_k0", first_rv, -1);
    end
    check("rows_out", pops, k);
    check("queue_empty", exp_q.size(), 0);
    check("preload_1cyc", preload_cnt, 1);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("cmd_ready_back", {cmd_ready, busy}, 2'b10);
  endtask

  task automatic run_cmd(input int k, input int a_mode, input int r_mode);
    issue_cmd(k);
    finished = 0;
    fork
      drive_a(k, a_mode);
      drive_r(r_mode);
      wait_done(k);
    join
    @(posedge clk); #1;
  endtask

  task automatic set_identity();
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) cur_w[i][j] = (i == j) ? 1.0 : 0.0;
  endtask

  task automatic randomize_cmd(input int k);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) cur_w[i][j] = $itor($urandom_range(0, 6)) - 3.0;
    for (int r = 0; r < k; r++)
      for (int i = 0; i < M; i++)
        a_buf[r][i*64 +: 64] = $realtobits($itor($urandom_range(0, 20)) - 10.0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_rows = '0; cmd_weights = '0;
    a_valid = 1'b0; a_data = '0; r_ready = 1'b0; sa_out_bottom = '0;
    for (int c = 0; c < H; c++)
      for (int i = 0; i < M; i++) hist[c][i] = '0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) w_sa[i][j] = 0.0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", {cmd_ready, busy, done, r_valid, a_ready, sa_preload_valid, r_last}, 0);
    check("rst_data", {|sa_preload_data, |sa_in_left, |r_data, |sa_in_top, sa_output_stationary}, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("cmd_ready_release0", cmd_ready, 0);
    @(negedge clk);
    check("cmd_ready_release1", cmd_ready, 1);
    @(posedge clk); #1;

    // Identity, two rows, free-flowing consumer
    set_identity();
    a_buf[0] = row3(1.0, 2.0, 3.0);
    a_buf[1] = row3(4.0, 5.0, 6.0);
    run_cmd(2, 0, 0);

    // Mixed weights, single row: expected [10,13,0]
    cur_w = '{'{2.0, 3.0, 0.0}, '{4.0, 5.0, 0.0}, '{0.0, 0.0, 0.0}};
    a_buf[0] = row3(1.0, 2.0, 0.0);
    run_cmd(1, 0, 0);

    // Backpressure: credit stall with consumer held off
    randomize_cmd(8);
    run_cmd(8, 0, 2);

    // Gapped A stream
    set_identity();
    for (int r = 0; r < 3; r++) a_buf[r] = row3($itor(r) + 1.5, $itor(r) * 2.0, -7.0);
    run_cmd(3, 1, 0);

    // Empty command
    run_cmd(0, 0, 0);

    // Reset mid-stream with two rows in flight
    randomize_cmd(4);
    issue_cmd(4);
    t = 0;
    while (beats < 2 && t < 50) begin
      a_valid = 1'b1;
      a_data  = a_buf[beats];
      @(negedge clk);
      @(posedge clk); #1;
      t++;
    end
    a_valid = 1'b0;
    check("rst_inflight_rows", beats - pops, 2);
    reset_n = 1'b0;
    #1;
    check("midrst_ctrl", {cmd_ready, busy, done, r_valid, a_ready, sa_preload_valid}, 0);
    check("midrst_data", {|sa_in_left, |r_data}, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    randomize_cmd(1);
    run_cmd(1, 0, 0);

    // Randomized commands
    for (int c = 0; c < 8; c++) begin
      t = $urandom_range(1, 7);
      randomize_cmd(t);
      run_cmd(t, $urandom_range(0, 2), $urandom_range(0, 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
